// File: rtl/vector_lane_recaller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vector_lane_recaller
//
// Receiving end of the dispatcher->lanes path in the vector function unit.
// Each accepted beat carries one element per lane. Beats are assembled into a
// full vector register image. After the last beat for the active vector length
// (vl), the image is offered to writeback with a valid/ready handshake.
//
// Optional feature macro: VECTOR_RECALLER_MASK_EN
//   When defined, adds mask_in and old_data_in, both sampled with start_in.
//   The image starts from old_data_in instead of zero, and only elements with
//   index < vl and mask bit set are overwritten.
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   start_in         in   begin a collection (honoured only in IDLE)
//   vl_in            in   active length 0..VECTOR_SIZE, sampled with start_in
//   busy_out         out  recaller not idle
//   lane_valid_in    in   lanes present a beat
//   lane_ready_out   out  recaller accepts a beat (COLLECT only)
//   lane_data_in     in   lane k at bits [k*LEN +: LEN]
//   result_valid_out out  assembled vector available
//   result_ready_in  in   writeback consumes the result
//   result_out       out  element i at bits [i*LEN +: LEN]
//   mask_in          in   (mask build) per-element write enable
//   old_data_in      in   (mask build) prior contents of the destination
// -----------------------------------------------------------------------------
module vector_lane_recaller #(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LANE_SIZE        = 2,
  parameter int LANE_INDEX_SIZE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_in,
  input  logic [ENTRY_INDEX_SIZE:0]     vl_in,
  output logic                          busy_out,
  input  logic                          lane_valid_in,
  output logic                          lane_ready_out,
  input  logic [LANE_SIZE*LEN-1:0]      lane_data_in,
  output logic                          result_valid_out,
  input  logic                          result_ready_in,
  output logic [VECTOR_SIZE*LEN-1:0]    result_out
`ifdef VECTOR_RECALLER_MASK_EN
  ,
  input  logic [VECTOR_SIZE-1:0]        mask_in,
  input  logic [VECTOR_SIZE*LEN-1:0]    old_data_in
`endif
);

  localparam int VL_W  = ENTRY_INDEX_SIZE + 1;
  localparam int PTR_W = ENTRY_INDEX_SIZE - LANE_INDEX_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [VL_W-1:0]              vl_q;
  logic [PTR_W-1:0]             beat_ptr;
  logic [VECTOR_SIZE*LEN-1:0]   result_q;
`ifdef VECTOR_RECALLER_MASK_EN
  logic [VECTOR_SIZE-1:0]       mask_q;
`endif

  logic                         start_accept;
  logic                         transfer;
  logic [VL_W-1:0]              beat_count;
  logic                         last_hit;
  logic [VECTOR_SIZE-1:0]       elem_we;

  // ceil(vl / LANE_SIZE); cannot overflow VL_W since vl <= VECTOR_SIZE.
  assign beat_count = (vl_q + VL_W'(LANE_SIZE - 1)) >> LANE_INDEX_SIZE;
  // Only evaluated in COLLECT, where vl_q >= 1, so beat_count - 1 is valid.
  assign last_hit   = (VL_W'(beat_ptr) == (beat_count - VL_W'(1)));

  assign start_accept = (state == IDLE) && start_in;
  assign transfer     = (state == COLLECT) && lane_valid_in;

  // Handshake outputs decode the state register only, so lane_valid_in never
  // reaches lane_ready_out combinationally.
  assign busy_out         = (state != IDLE);
  assign lane_ready_out   = (state == COLLECT);
  assign result_valid_out = (state == DONE);
  assign result_out       = result_q;

  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update from the same pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaulting state_next before the case keeps every path assigned,
    // so no latch is inferred when a branch leaves the state unchanged.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_in) state_next = (vl_in == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (transfer && last_hit) state_next = DONE;
      end
      DONE: begin
        // start_in is deliberately ignored here, even alongside the handshake.
        if (result_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Element i belongs to beat i/LANE_SIZE, lane i%LANE_SIZE. It is written
  // only when that beat transfers and the element lies inside vl.
  always_comb begin
    elem_we = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      elem_we[i] = transfer
                && (beat_ptr == PTR_W'(i / LANE_SIZE))
                && (VL_W'(i) < vl_q)
`ifdef VECTOR_RECALLER_MASK_EN
                && mask_q[i]
`endif
                ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vl_q     <= '0;
      beat_ptr <= '0;
      // NOTE: the result register is reset (not left uninitialised like a
      // storage array) because result_out must read zero straight after rst.
      result_q <= '0;
`ifdef VECTOR_RECALLER_MASK_EN
      mask_q   <= '0;
`endif
    end else if (start_accept) begin
      vl_q     <= vl_in;
      beat_ptr <= '0;
`ifdef VECTOR_RECALLER_MASK_EN
      mask_q   <= mask_in;
      result_q <= old_data_in;
`else
      result_q <= '0;
`endif
    end else if (transfer) begin
      // Pointer holds on the final beat so it never wraps within an op.
      if (!last_hit) beat_ptr <= beat_ptr + PTR_W'(1);
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        if (elem_we[i]) begin
          result_q[i*LEN +: LEN] <= lane_data_in[(i % LANE_SIZE)*LEN +: LEN];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_lane_recaller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vector_lane_recaller
//
// Self-checking bench for vector_lane_recaller. Each operation pushes the
// vector the bench expects onto a scoreboard queue when its stimulus is
// driven; the entry is popped and compared once the DUT presents its result.
// Beat b, lane k of an operation carries base + b*LANE_SIZE + k, so element i
// is expected to hold base + i when written.
// -----------------------------------------------------------------------------
module tb_vector_lane_recaller;

  localparam int LEN = 32;
  localparam int VS  = 8;
  localparam int EIS = 3;
  localparam int LS  = 2;
  localparam int LIS = 1;
  localparam int VW  = VS * LEN;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_in;
  logic [EIS:0]      vl_in;
  logic              busy_out;
  logic              lane_valid_in;
  logic              lane_ready_out;
  logic [LS*LEN-1:0] lane_data_in;
  logic              result_valid_out;
  logic              result_ready_in;
  logic [VW-1:0]     result_out;
`ifdef VECTOR_RECALLER_MASK_EN
  logic [VS-1:0]     mask_in;
  logic [VW-1:0]     old_data_in;
`endif

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] sb_q[$];

  vector_lane_recaller #(
    .LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS),
    .LANE_SIZE(LS), .LANE_INDEX_SIZE(LIS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .vl_in            (vl_in),
    .busy_out         (busy_out),
    .lane_valid_in    (lane_valid_in),
    .lane_ready_out   (lane_ready_out),
    .lane_data_in     (lane_data_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_out       (result_out)
`ifdef VECTOR_RECALLER_MASK_EN
    ,
    .mask_in          (mask_in),
    .old_data_in      (old_data_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: start from old, overwrite in-range enabled elements.
  function automatic logic [VW-1:0] model(input int vl, input logic [31:0] base,
                                          input logic [VS-1:0] mask,
                                          input logic [VW-1:0] old);
    logic [VW-1:0] r;
    r = old;
    for (int i = 0; i < VS; i++) begin
      if (i < vl && mask[i]) r[i*LEN +: LEN] = base + 32'(i);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] old_pattern();
    logic [VW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*LEN +: LEN] = 32'hDEAD_0000 + 32'(i);
    return r;
  endfunction

  // Start an op, feed its beats, and stop in DONE.
  task automatic op_collect(input int vl, input logic [31:0] base,
                            input logic [VS-1:0] mask, input logic [VW-1:0] old,
                            input bit gaps);
    int   nbeats;
    int   b;
    int   cycles;
    logic v;
    nbeats = (vl + LS - 1) / LS;
    sb_q.push_back(model(vl, base, mask, old));
    start_in = 1'b1;
    vl_in    = (EIS+1)'(vl);
`ifdef VECTOR_RECALLER_MASK_EN
    mask_in     = mask;
    old_data_in = old;
`endif
    tick();
    start_in = 1'b0;
    b = 0;
    cycles = 0;
    while (b < nbeats && cycles < 200) begin
      checks++;
      if (lane_ready_out !== 1'b1) begin
        errors++;
        $display("FAIL lane_ready_collect vl=%0d beat=%0d: got %b want 1", vl, b, lane_ready_out);
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      lane_valid_in = v;
      for (int k = 0; k < LS; k++) lane_data_in[k*LEN +: LEN] = base + 32'(b*LS + k);
      tick();
      if (v) b++;
      cycles++;
    end
    lane_valid_in = 1'b0;
    lane_data_in  = {$urandom, $urandom};
    if (b < nbeats) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout vl=%0d: got %0d beats want %0d", vl, b, nbeats);
    end
    checks++;
    if (result_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL result_valid_latency vl=%0d: got %b want 1", vl, result_valid_out);
    end
    checks++;
    if (lane_ready_out !== 1'b0 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL done_flags vl=%0d: got ready=%b busy=%b want ready=0 busy=1",
               vl, lane_ready_out, busy_out);
    end
  endtask

  // Pop the expected vector, compare, then complete the handshake.
  task automatic op_drain(input bit start_too);
    logic [VW-1:0] exp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    exp = sb_q.pop_front();
    if (result_out !== exp) begin
      errors++;
      $display("FAIL result_data: got %h want %h", result_out, exp);
    end
    result_ready_in = 1'b1;
    start_in        = start_too;
    vl_in           = 4'd4;
    tick();
    result_ready_in = 1'b0;
    start_in        = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || result_valid_out !== 1'b0 || lane_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_handshake: got busy=%b valid=%b ready=%b want 0 0 0",
               busy_out, result_valid_out, lane_ready_out);
    end
    checks++;
    if (result_out !== exp) begin
      errors++;
      $display("FAIL result_held_idle: got %h want %h", result_out, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || lane_ready_out !== 1'b0 || result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b ready=%b valid=%b want 0 0 0",
               busy_out, lane_ready_out, result_valid_out);
    end
    checks++;
    if (result_out !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h want 0", result_out);
    end
  endtask

  task automatic test_full_vector();
    op_collect(8, 32'h100, '1, '0, 1'b0);
    op_drain(1'b0);
  endtask

  task automatic test_partial_vl();
    op_collect(5, 32'h100, '1, '0, 1'b0);
    op_drain(1'b0);
  endtask

  task automatic test_zero_vl();
    op_collect(0, 32'h400, '1, '0, 1'b0);
    op_drain(1'b0);
  endtask

  task automatic test_done_hold();
    logic [VW-1:0] exp;
    op_collect(3, 32'h200, '1, '0, 1'b0);
    exp = model(3, 32'h200, '1, '0);
    for (int c = 0; c < 3; c++) begin
      result_ready_in = 1'b0;
      start_in        = (c == 1);
      vl_in           = 4'd8;
      lane_valid_in   = 1'b1;
      lane_data_in    = {$urandom, $urandom};
      tick();
      start_in = 1'b0;
      checks++;
      if (result_valid_out !== 1'b1 || busy_out !== 1'b1 || result_out !== exp) begin
        errors++;
        $display("FAIL done_hold c=%0d: got valid=%b busy=%b data=%h want 1 1 %h",
                 c, result_valid_out, busy_out, result_out, exp);
      end
    end
    lane_valid_in = 1'b0;
    op_drain(1'b1);
  endtask

  task automatic test_reset_in_collect();
    start_in = 1'b1;
    vl_in    = 4'd8;
    tick();
    start_in = 1'b0;
    for (int b = 0; b < 2; b++) begin
      lane_valid_in = 1'b1;
      for (int k = 0; k < LS; k++) lane_data_in[k*LEN +: LEN] = 32'h500 + 32'(b*LS + k);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || lane_ready_out !== 1'b0 || result_valid_out !== 1'b0
        || result_out !== '0) begin
      errors++;
      $display("FAIL reset_in_collect: got busy=%b ready=%b valid=%b data=%h want all 0",
               busy_out, lane_ready_out, result_valid_out, result_out);
    end
    tick();
    lane_valid_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || result_out !== '0) begin
      errors++;
      $display("FAIL lane_valid_in_idle: got busy=%b data=%h want 0 0", busy_out, result_out);
    end
    op_collect(2, 32'hA, '1, '0, 1'b0);
    op_drain(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      op_collect(int'($urandom_range(0, VS)), $urandom, '1, '0, 1'b1);
      op_drain(1'b0);
    end
  endtask

`ifdef VECTOR_RECALLER_MASK_EN
  task automatic test_mask();
    op_collect(8, 32'h100, 8'b1010_1010, old_pattern(), 1'b0);
    op_drain(1'b0);
    op_collect(5, 32'h700, 8'b0110_0111, old_pattern(), 1'b1);
    op_drain(1'b0);
  endtask
`endif

  initial begin
    rst             = 1'b1;
    start_in        = 1'b0;
    vl_in           = '0;
    lane_valid_in   = 1'b0;
    lane_data_in    = '0;
    result_ready_in = 1'b0;
`ifdef VECTOR_RECALLER_MASK_EN
    mask_in         = '0;
    old_data_in     = '0;
`endif
    test_reset();
    test_full_vector();
    test_partial_vl();
    test_zero_vl();
    test_done_hold();
    test_reset_in_collect();
    test_back_to_back();
`ifdef VECTOR_RECALLER_MASK_EN
    test_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
